// File: rtl/nzcv_flag_unit.sv
// rtl/nzcv_flag_unit.sv - registered NZCV flag pipeline with sticky Q and forwarded condition evaluation
module nzcv_flag_unit #(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  input  logic [M-1:0] Result,
  input  logic [3:0]   ALUControl,
  input  logic         Cout,
  input  logic         in_valid,
  input  logic [1:0]   FlagWrite,
  input  logic         flags_wr_en,
  input  logic [3:0]   flags_wr_data,
  input  logic         q_clear,
  input  logic [3:0]   Cond,
  input  logic         cond_valid,
  output logic         CondEx,
  output logic [3:0]   Flags,
  output logic         Q
);

  logic       is_add, is_sub, is_arith;
  logic       raw_n, raw_z, raw_c, raw_v;
  logic [1:0] raw_mask;

  logic       pend_valid;
  logic [3:0] pend_flags;
  logic [1:0] pend_mask;

  logic [3:0] eff;
  logic       cond_pass;
  logic       unused_bits;

  assign unused_bits = ^{A[M-2:0], B[M-2:0]};

  assign is_add   = (ALUControl == 4'b0000);
  assign is_sub   = (ALUControl == 4'b0001);
  assign is_arith = is_add | is_sub;

  assign raw_n = Result[M-1];
  assign raw_z = ~|Result;
  assign raw_c = Cout;
  assign raw_v = is_add ? (~(A[M-1] ^ B[M-1]) & (A[M-1] ^ Result[M-1]))
                        : ((A[M-1] ^ B[M-1]) & (A[M-1] ^ Result[M-1]));

  // Logic/MUL ops never produce C,V, so their CV group can never be written.
  assign raw_mask = {FlagWrite[1], FlagWrite[0] & is_arith};

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_flags <= 4'b0000;
      pend_mask  <= 2'b00;
      Flags      <= 4'b0000;
      Q          <= 1'b0;
    end else begin
      pend_valid <= in_valid & (FlagWrite != 2'b00);
      if (in_valid && FlagWrite != 2'b00) begin
        pend_flags <= {raw_n, raw_z, raw_c, raw_v};
        pend_mask  <= raw_mask;
      end

      // A direct load overrides and discards the entry committing this edge.
      if (flags_wr_en) begin
        Flags <= flags_wr_data;
      end else if (pend_valid) begin
        if (pend_mask[1]) Flags[3:2] <= pend_flags[3:2];
        if (pend_mask[0]) Flags[1:0] <= pend_flags[1:0];
      end

      if (!flags_wr_en && pend_valid && pend_mask[0] && pend_flags[0])
        Q <= 1'b1;
      else if (q_clear)
        Q <= 1'b0;
    end
  end

  always_comb begin
    eff = Flags;
    if (pend_valid) begin
      if (pend_mask[1]) eff[3:2] = pend_flags[3:2];
      if (pend_mask[0]) eff[1:0] = pend_flags[1:0];
    end
  end

  always_comb begin
    cond_pass = 1'b1;
    case (Cond)
      4'b0000: cond_pass = eff[2];
      4'b0001: cond_pass = ~eff[2];
      4'b0010: cond_pass = eff[1];
      4'b0011: cond_pass = ~eff[1];
      4'b0100: cond_pass = eff[3];
      4'b0101: cond_pass = ~eff[3];
      4'b0110: cond_pass = eff[0];
      4'b0111: cond_pass = ~eff[0];
      4'b1000: cond_pass = eff[1] & ~eff[2];
      4'b1001: cond_pass = ~eff[1] | eff[2];
      4'b1010: cond_pass = (eff[3] == eff[0]);
      4'b1011: cond_pass = (eff[3] != eff[0]);
      4'b1100: cond_pass = ~eff[2] & (eff[3] == eff[0]);
      4'b1101: cond_pass = eff[2] | (eff[3] != eff[0]);
      default: cond_pass = 1'b1;
    endcase
  end

  assign CondEx = ~reset & cond_valid & cond_pass;

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// tb/tb_nzcv_flag_unit.sv - directed self-checking bench for nzcv_flag_unit (M=8)
module tb_nzcv_flag_unit;
  localparam int M = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [M-1:0] A, B, Result;
  logic [3:0]   ALUControl;
  logic         Cout, in_valid;
  logic [1:0]   FlagWrite;
  logic         flags_wr_en;
  logic [3:0]   flags_wr_data;
  logic         q_clear;
  logic [3:0]   Cond;
  logic         cond_valid;
  logic         CondEx;
  logic [3:0]   Flags;
  logic         Q;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nzcv_flag_unit #(.M(M)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .Result(Result),
    .ALUControl(ALUControl), .Cout(Cout), .in_valid(in_valid),
    .FlagWrite(FlagWrite), .flags_wr_en(flags_wr_en), .flags_wr_data(flags_wr_data),
    .q_clear(q_clear), .Cond(Cond), .cond_valid(cond_valid),
    .CondEx(CondEx), .Flags(Flags), .Q(Q)
  );

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp;
  } cond_vec_t;

  cond_vec_t cv[24];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [3:0] ctl, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] r, input logic c, input logic [1:0] fw);
    ALUControl = ctl; A = a; B = b; Result = r; Cout = c; FlagWrite = fw; in_valid = 1'b1;
  endtask

  initial begin
    cv[0]  = '{4'b0100, 4'b0000, 1'b1};
    cv[1]  = '{4'b0100, 4'b0001, 1'b0};
    cv[2]  = '{4'b0100, 4'b1001, 1'b1};
    cv[3]  = '{4'b0100, 4'b1000, 1'b0};
    cv[4]  = '{4'b0100, 4'b1100, 1'b0};
    cv[5]  = '{4'b0100, 4'b1101, 1'b1};
    cv[6]  = '{4'b0010, 4'b0010, 1'b1};
    cv[7]  = '{4'b0010, 4'b0011, 1'b0};
    cv[8]  = '{4'b0010, 4'b1000, 1'b1};
    cv[9]  = '{4'b0010, 4'b1001, 1'b0};
    cv[10] = '{4'b1000, 4'b0100, 1'b1};
    cv[11] = '{4'b1000, 4'b0101, 1'b0};
    cv[12] = '{4'b1000, 4'b1010, 1'b0};
    cv[13] = '{4'b1000, 4'b1011, 1'b1};
    cv[14] = '{4'b1000, 4'b1100, 1'b0};
    cv[15] = '{4'b1000, 4'b1101, 1'b1};
    cv[16] = '{4'b1001, 4'b1010, 1'b1};
    cv[17] = '{4'b1001, 4'b1011, 1'b0};
    cv[18] = '{4'b1001, 4'b1100, 1'b1};
    cv[19] = '{4'b1001, 4'b0110, 1'b1};
    cv[20] = '{4'b1001, 4'b0111, 1'b0};
    cv[21] = '{4'b0000, 4'b1110, 1'b1};
    cv[22] = '{4'b0000, 4'b1111, 1'b1};
    cv[23] = '{4'b0000, 4'b0111, 1'b1};

    reset = 1'b1; A = '0; B = '0; Result = '0; ALUControl = 4'b0000; Cout = 1'b0;
    in_valid = 1'b0; FlagWrite = 2'b00; flags_wr_en = 1'b0; flags_wr_data = 4'b0000;
    q_clear = 1'b0; Cond = 4'b1110; cond_valid = 1'b1;

    // reset state
    tick; tick;
    check("reset_flags", {4'b0, Flags}, 8'h00);
    check("reset_q", {7'b0, Q}, 8'h00);
    check("reset_condex_al", {7'b0, CondEx}, 8'h00);
    reset = 1'b0;
    cond_valid = 1'b0;

    // ADD overflow, forwarded VS, then commit
    alu(4'b0000, 8'h7F, 8'h01, 8'h80, 1'b0, 2'b11);
    tick;
    in_valid = 1'b0; Cond = 4'b0110; cond_valid = 1'b1;
    #1 check("add_vs_fwd", {7'b0, CondEx}, 8'h01);
    check("add_flags_pre", {4'b0, Flags}, 8'h00);
    tick;
    check("add_flags", {4'b0, Flags}, 8'h09);
    check("add_q", {7'b0, Q}, 8'h01);
    check("add_vs_commit", {7'b0, CondEx}, 8'h01);

    // SUB equal, EQ forwarded before commit
    alu(4'b0001, 8'h05, 8'h05, 8'h00, 1'b1, 2'b11);
    tick;
    in_valid = 1'b0; Cond = 4'b0000;
    #1 check("sub_eq_fwd", {7'b0, CondEx}, 8'h01);
    check("sub_flags_pre", {4'b0, Flags}, 8'h09);
    tick;
    check("sub_flags", {4'b0, Flags}, 8'h06);
    cond_valid = 1'b0;
    #1 check("cond_valid_low", {7'b0, CondEx}, 8'h00);

    // AND preserves C,V
    alu(4'b0010, 8'hF0, 8'h80, 8'h80, 1'b0, 2'b11);
    tick; in_valid = 1'b0; tick;
    check("and_flags", {4'b0, Flags}, 8'h0A);

    q_clear = 1'b1; tick; q_clear = 1'b0;
    check("q_clear", {7'b0, Q}, 8'h00);

    // CV-only ADD keeps N,Z
    alu(4'b0000, 8'h80, 8'h80, 8'h00, 1'b1, 2'b01);
    tick; in_valid = 1'b0; tick;
    check("add_cv_only_flags", {4'b0, Flags}, 8'h0B);
    check("add_cv_only_q", {7'b0, Q}, 8'h01);

    // set beats same-edge clear
    q_clear = 1'b1; tick; q_clear = 1'b0;
    check("q_clear2", {7'b0, Q}, 8'h00);
    alu(4'b0000, 8'h7F, 8'h01, 8'h80, 1'b0, 2'b11);
    tick; in_valid = 1'b0; q_clear = 1'b1;
    tick; q_clear = 1'b0;
    check("q_set_wins", {7'b0, Q}, 8'h01);
    check("q_set_flags", {4'b0, Flags}, 8'h09);

    // direct load collides with commit; pending discarded
    alu(4'b0001, 8'h05, 8'h05, 8'h00, 1'b1, 2'b11);
    tick; in_valid = 1'b0; flags_wr_en = 1'b1; flags_wr_data = 4'b0100;
    tick; flags_wr_en = 1'b0;
    check("wr_collide", {4'b0, Flags}, 8'h04);
    tick;
    check("wr_no_late_commit", {4'b0, Flags}, 8'h04);
    check("wr_keeps_q", {7'b0, Q}, 8'h01);

    // entry captured on a load edge still commits next edge
    alu(4'b0001, 8'h05, 8'h05, 8'h00, 1'b1, 2'b11);
    flags_wr_en = 1'b1; flags_wr_data = 4'b1000;
    tick; in_valid = 1'b0; flags_wr_en = 1'b0;
    check("wr_same_capture", {4'b0, Flags}, 8'h08);
    tick;
    check("capture_commits", {4'b0, Flags}, 8'h06);

    // back-to-back ops, disjoint masks
    alu(4'b0000, 8'h7F, 8'h01, 8'h80, 1'b0, 2'b10);
    tick;
    alu(4'b0000, 8'h7F, 8'h01, 8'h80, 1'b0, 2'b01);
    tick; in_valid = 1'b0;
    check("b2b_first", {4'b0, Flags}, 8'h0A);
    tick;
    check("b2b_second", {4'b0, Flags}, 8'h09);

    // logic op with CV-only write changes nothing
    alu(4'b0101, 8'h00, 8'h00, 8'h00, 1'b1, 2'b01);
    tick; in_valid = 1'b0; tick;
    check("mul_cv_masked", {4'b0, Flags}, 8'h09);

    // condition table
    for (int i = 0; i < 24; i++) begin
      cond_valid = 1'b0;
      flags_wr_en = 1'b1; flags_wr_data = cv[i].flags;
      tick;
      flags_wr_en = 1'b0;
      Cond = cv[i].cond; cond_valid = 1'b1;
      #1 check($sformatf("cond_%0d_f%b_c%b", i, cv[i].flags, cv[i].cond), {7'b0, CondEx}, {7'b0, cv[i].exp});
    end
    cond_valid = 1'b0;

    // reset drops a pending entry
    flags_wr_en = 1'b1; flags_wr_data = 4'b0000; tick; flags_wr_en = 1'b0;
    alu(4'b0000, 8'h7F, 8'h01, 8'h80, 1'b0, 2'b11);
    tick; in_valid = 1'b0; reset = 1'b1; cond_valid = 1'b1; Cond = 4'b1110;
    #1 check("reset_condex_forced", {7'b0, CondEx}, 8'h00);
    tick; reset = 1'b0; cond_valid = 1'b0;
    check("reset_drop_flags", {4'b0, Flags}, 8'h00);
    check("reset_drop_q", {7'b0, Q}, 8'h00);
    tick;
    check("reset_no_late", {4'b0, Flags}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
